// File: rtl/conv_seq_pkg.sv
// conv_seq_pkg: state encoding, default counter width and kernel clamp for conv_tile_sequencer
package conv_seq_pkg;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;
    localparam int CNT_W_DEF = 32;
    function automatic logic [3:0] k_clamp(input logic [3:0] k, input logic [3:0] k_max);
        return (k == 4'd0) ? 4'd1 : (k > k_max) ? k_max : k;
    endfunction
endpackage

// File: rtl/seq_delay_line.sv
// seq_delay_line: DEPTH-stage shift register that only advances while en is high
module seq_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] pipe [DEPTH];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
        end else if (en) begin
            pipe[0] <= d;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign q = pipe[DEPTH-1];
endmodule

// File: rtl/conv_tile_sequencer.sv
// conv_tile_sequencer: per-tile LOAD/STREAM sequencing of a conv layer for the PE array.
// Optional perf counters enabled by defining SEQ_PERF_CNT_EN.
module conv_tile_sequencer
    import conv_seq_pkg::*;
#(
    parameter int K_MAX      = 3,
    parameter int T          = 16,
    parameter int PIPE_DEPTH = 4,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             start_conv,
    input  logic             start_tile,
    input  logic [3:0]       cfg_k,
    input  logic [CNT_W-1:0] cfg_ci,
    input  logic [CNT_W-1:0] cfg_tiles,
    output logic             ifm_read,
    output logic             wgt_read,
    output logic             p_valid_o,
    output logic             last_channel_o,
    output logic             tile_done,
    output logic             end_conv,
    output logic             busy,
    output logic [CNT_W-1:0] perf_active,
    output logic [CNT_W-1:0] perf_stall
);
    localparam int PW = $clog2(K_MAX + T + 1);
    logic [1:0]       state;
    logic [PW-1:0]    phase_cnt;
    logic [3:0]       k_eff;
    logic [CNT_W-1:0] ci_r, tiles_r, ch_cnt, tile_cnt, tiles_nx;
    logic             load_last, stream_last, ch_last, p_valid, last_ch;
    logic [1:0]       pipe_q;

    // a same-cycle start_conv supplies the tile limit for the FINISH decision
    assign tiles_nx    = start_conv ? cfg_tiles : tiles_r;
    assign load_last   = phase_cnt == PW'(k_eff - 4'd1);
    assign stream_last = phase_cnt == PW'(T - 2);
    assign ch_last     = ch_cnt == ci_r - CNT_W'(1);
    assign busy        = state != S_IDLE;
    assign ifm_read    = state == S_LOAD || state == S_STREAM;
    assign wgt_read    = state == S_LOAD;
    assign end_conv    = state == S_FINISH;
    assign p_valid     = state == S_STREAM || (state == S_LOAD && load_last);
    assign last_ch     = p_valid && ch_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            phase_cnt <= '0;
            k_eff     <= 4'd1;
            ci_r      <= CNT_W'(1);
            tiles_r   <= '0;
            ch_cnt    <= '0;
            tile_cnt  <= '0;
            tile_done <= 1'b0;
        end else if (!stall) begin
            tile_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_conv) begin
                        k_eff   <= k_clamp(cfg_k, 4'(K_MAX));
                        ci_r    <= (cfg_ci == '0) ? CNT_W'(1) : cfg_ci;
                        tiles_r <= cfg_tiles;
                    end
                    if (start_tile) begin
                        state     <= (tile_cnt == tiles_nx) ? S_FINISH : S_LOAD;
                        phase_cnt <= '0;
                    end
                end
                S_LOAD: begin
                    state     <= load_last ? S_STREAM : S_LOAD;
                    phase_cnt <= load_last ? '0 : phase_cnt + PW'(1);
                end
                S_STREAM: begin
                    if (stream_last) begin
                        phase_cnt <= '0;
                        state     <= ch_last ? S_IDLE : S_LOAD;
                        ch_cnt    <= ch_last ? '0 : ch_cnt + CNT_W'(1);
                        tile_done <= ch_last;
                        if (ch_last && tile_cnt != tiles_r) tile_cnt <= tile_cnt + CNT_W'(1);
                    end else begin
                        phase_cnt <= phase_cnt + PW'(1);
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    tile_cnt <= '0;
                    ch_cnt   <= '0;
                end
            endcase
        end
    end

    seq_delay_line #(.WIDTH(2), .DEPTH(PIPE_DEPTH)) u_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (!stall),
        .d     ({p_valid, last_ch}),
        .q     (pipe_q)
    );
    assign p_valid_o      = pipe_q[1];
    assign last_channel_o = pipe_q[0];

`ifdef SEQ_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_active <= '0;
            perf_stall  <= '0;
        end else if (!stall && !busy && start_conv) begin
            perf_active <= '0;
            perf_stall  <= '0;
        end else if (busy) begin
            if (stall) perf_stall <= perf_stall + CNT_W'(perf_stall != '1);
            else perf_active <= perf_active + CNT_W'(perf_active != '1);
        end
    end
`else
    assign perf_active = '0;
    assign perf_stall  = '0;
`endif
endmodule
